i2c_rx_controller: RTL

I2C_RX_CONTROLLER -- requirements
Module: i2c_rx_controller

---
 rtl/i2c_rx_controller.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/i2c_rx_controller.sv
// Serial frame receiver: start bit, length header, N data bytes with per-byte
// ack, stop slot; received bytes land in a 2-entry FIFO drained by the consumer.
module i2c_rx_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdaIn,
  output logic       ackOut,
  input  logic       rdEn,
  output logic [7:0] dataOut,
  output logic       dataValid,
  output logic [7:0] burstLen,
  output logic       frameDone,
  output logic       nackErr,
  output logic       frmErr,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, HDR, HACK, DATA, DACK, STOP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  bitCnt;
  logic [7:0]  shReg;
  logic [7:0]  shNext;
  logic [7:0]  remCnt;
  logic [7:0]  tailReg;
  logic [1:0]  count;
  logic        aborted;
  logic        space;
  logic        push;
  logic        pop;

  // Handshake: a byte is pushed only in DACK with space; the consumer pops with
  // rdEn while dataValid=1, and a pop in the same cycle frees the slot it needs.
  always_comb begin
    shNext = {shReg[6:0], sdaIn};
    space  = (count < 2'd2) || ((count == 2'd2) && rdEn);
    pop    = rdEn && (count != 2'd0);
    push   = (state == DACK) && space;
    ackOut = !((state == HACK) || ((state == DACK) && space));
    dataValid = (count != 2'd0);
    busy      = (state != IDLE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!sdaIn) state_nxt = HDR;
      HDR:  if (bitCnt == 3'd7) state_nxt = HACK;
      HACK: state_nxt = (burstLen == 8'd0) ? STOP : DATA;
      DATA: if (bitCnt == 3'd7) state_nxt = DACK;
      DACK: begin
        if (space && (remCnt != 8'd1)) state_nxt = DATA;
        else                           state_nxt = STOP;
      end
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bitCnt    <= 3'd0;
      shReg     <= 8'h00;
      remCnt    <= 8'h00;
      burstLen  <= 8'h00;
      aborted   <= 1'b0;
      frameDone <= 1'b0;
      nackErr   <= 1'b0;
      frmErr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      // An overflow-aborted frame never reports a good stop; a bad stop slot
      // is still flagged.
      frameDone <= (state == STOP) && sdaIn && !aborted;
      frmErr    <= (state == STOP) && !sdaIn;
      nackErr   <= (state == DACK) && !space;
      case (state)
        IDLE: begin
          bitCnt  <= 3'd0;
          aborted <= 1'b0;
        end
        HDR: begin
          shReg  <= shNext;
          bitCnt <= bitCnt + 3'd1;
          if (bitCnt == 3'd7) begin
            burstLen <= shNext;
            remCnt   <= shNext;
          end
        end
        DATA: begin
          shReg  <= shNext;
          bitCnt <= bitCnt + 3'd1;
        end
        DACK: begin
          if (space) remCnt  <= remCnt - 8'd1;
          else       aborted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // dataOut is a real register holding the head so it keeps its value once
  // the buffer drains; tailReg is the second slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataOut <= 8'h00;
      tailReg <= 8'h00;
      count   <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            dataOut <= shReg;
            count   <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            dataOut <= shReg;
          end else if (push) begin
            tailReg <= shReg;
            count   <= 2'd2;
          end else if (pop) begin
            count   <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            dataOut <= tailReg;
            if (push) tailReg <= shReg;
            else      count   <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

endmodule
